// File: rtl/array_select_sequencer_if.sv
// Handshake and configuration bundle for array_select_sequencer.
//   master : producer/consumer/config side (drives in_*, out_ready, cfg_*)
//   slave  : sequencer side (drives in_ready, out_valid, out_data[, cfg_err])
// Optional: ARRAY_SELECT_CFG_ERR_EN adds cfg_err (sequencer -> master).
interface array_select_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = 4
);
  localparam int unsigned SEL_W = $clog2(2 * WIDTH);
  localparam int unsigned AW    = $clog2(STEPS);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [AW:0]            in_steps;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic [WIDTH*SEL_W-1:0] cfg_data;
`ifdef ARRAY_SELECT_CFG_ERR_EN
  logic                   cfg_err;
`endif

  modport master (
`ifdef ARRAY_SELECT_CFG_ERR_EN
    input  cfg_err,
`endif
    output in_valid, in_data, in_steps, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
`ifdef ARRAY_SELECT_CFG_ERR_EN
    output cfg_err,
`endif
    input  in_valid, in_data, in_steps, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/array_select_sequencer.sv
// Multi-pass bit-select engine. An accepted word is run through up to STEPS passes; each pass
// rebuilds every result bit from either the original word or the previous pass result, using a
// per-pass select map held in a programmable table. One pass per clock, one word in flight.
//
// Ports:
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset
//   bus (slave)  in_valid/in_ready/in_data/in_steps, out_valid/out_ready/out_data,
//                cfg_we/cfg_addr/cfg_data, and cfg_err when ARRAY_SELECT_CFG_ERR_EN is defined
//
// Optional: ARRAY_SELECT_CFG_ERR_EN -> cfg_err pulses one cycle after a table write that was
// attempted outside IDLE (such writes are always dropped).
module array_select_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = 4,
  parameter int unsigned SEL_W = $clog2(2 * WIDTH),
  parameter int unsigned AW    = $clog2(STEPS)
) (
  input logic                     CLK,
  input logic                     ASYNCRESETN,
  array_select_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       orig_q, orig_d;
  logic [WIDTH-1:0]       work_q, work_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [AW:0]            ncap_q, ncap_d;
  logic [AW-1:0]          step_q, step_d;
  logic [WIDTH*SEL_W-1:0] table_q [STEPS];

  logic                   accept;
  logic                   cfg_ok;
  logic                   last_pass;
  logic [AW:0]            steps_clamped;
  logic [WIDTH*SEL_W-1:0] cur_map;
  logic [2*WIDTH-1:0]     src;
  logic [SEL_W-1:0]       sel;
  logic [WIDTH-1:0]       pass_res;

  // in_ready is forced low while reset is asserted, not just after the state register clears.
  assign bus.in_ready  = (state_q == StIdle) & ASYNCRESETN;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign cfg_ok = bus.cfg_we & (state_q == StIdle);

  assign steps_clamped = (bus.in_steps > (AW+1)'(STEPS)) ? (AW+1)'(STEPS) : bus.in_steps;
  assign last_pass     = ({1'b0, step_q} == (ncap_q - 1'b1));

  // Shared select stage: sources 0..WIDTH-1 are orig, WIDTH..2*WIDTH-1 are work.
  assign cur_map = table_q[step_q];
  assign src     = {work_q, orig_q};

  always_comb begin
    pass_res = '0;
    sel      = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sel = cur_map[i*SEL_W +: SEL_W];
      if (32'(sel) < 2 * WIDTH) pass_res[i] = src[sel];
    end
  end

  always_comb begin
    state_d    = state_q;
    orig_d     = orig_q;
    work_d     = work_q;
    ncap_d     = ncap_q;
    step_d     = step_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          orig_d = bus.in_data;
          work_d = bus.in_data;
          ncap_d = steps_clamped;
          step_d = '0;
          if (steps_clamped == '0) begin
            state_d    = StDone;
            out_data_d = bus.in_data;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        work_d = pass_res;
        step_d = step_q + 1'b1;
        if (last_pass) begin
          state_d    = StDone;
          out_data_d = pass_res;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q    <= StIdle;
      orig_q     <= '0;
      work_q     <= '0;
      out_data_q <= '0;
      ncap_q     <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      orig_q     <= orig_d;
      work_q     <= work_d;
      out_data_q <= out_data_d;
      ncap_q     <= ncap_d;
      step_q     <= step_d;
    end
  end

  // Table resets to identity so an unprogrammed pass leaves the word unchanged.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int k = 0; k < int'(STEPS); k++) begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          table_q[k][i*SEL_W +: SEL_W] <= SEL_W'(i);
        end
      end
    end else if (cfg_ok && (32'(bus.cfg_addr) < STEPS)) begin
      table_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

`ifdef ARRAY_SELECT_CFG_ERR_EN
  logic cfg_err_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) cfg_err_q <= 1'b0;
    else              cfg_err_q <= bus.cfg_we & (state_q != StIdle);
  end

  assign bus.cfg_err = cfg_err_q;
`endif

endmodule

// File: tb/tb_array_select_sequencer.sv
// Directed bench for array_select_sequencer (WIDTH=4, STEPS=4). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_array_select_sequencer;

  logic CLK = 1'b0;
  logic ASYNCRESETN;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  array_select_sequencer_if #(.WIDTH(4), .STEPS(4)) bus ();

  array_select_sequencer #(.WIDTH(4), .STEPS(4)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus)
  );

  localparam logic [11:0] MapChain0 = {3'd2, 3'd1, 3'd0, 3'd0};
  localparam logic [11:0] MapChain1 = {3'd1, 3'd5, 3'd5, 3'd4};
  localparam logic [11:0] MapIdent  = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] MapRotl   = {3'd6, 3'd5, 3'd4, 3'd7};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [11:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(negedge CLK);
    bus.cfg_we   = 1'b0;
  endtask

  // Presents a word, lets it be accepted, returns at the falling edge after the accept edge.
  task automatic send(input logic [3:0] d, input logic [2:0] n);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_steps = n;
    check_eq("acc_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    bus.in_steps = 3'd5;
    if (n != 3'd0) check_eq("run_rdy", 32'(bus.in_ready), 32'd0);
  endtask

  // Counts falling edges from the post-accept edge until out_valid; bounded.
  task automatic wait_out(input string tag, input int exp_lat, input logic [3:0] exp_data);
    int cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    check_eq({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
    check_eq({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge CLK);
    check_eq("drain_rdy", 32'(bus.in_ready), 32'd1);
    check_eq("drain_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ASYNCRESETN   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_steps  = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;

    // Reset defaults
    @(negedge CLK);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    ASYNCRESETN = 1'b1;
    @(negedge CLK);
    check_eq("idle_rdy", 32'(bus.in_ready), 32'd1);

    // Identity table after reset
    send(4'b0110, 3'd2);
    wait_out("ident", 2, 4'b0110);
    check_eq("done_rdy", 32'(bus.in_ready), 32'd0);
    drain();

    // Two-pass chain with backpressure
    cfg_write(2'd0, MapChain0);
    cfg_write(2'd1, MapChain1);
    bus.out_ready = 1'b0;
    send(4'b0110, 3'd2);
    wait_out("chain", 2, 4'b1000);
    repeat (5) begin
      @(negedge CLK);
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_data", 32'(bus.out_data), 32'b1000);
      check_eq("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    drain();

    // Config write while running is dropped
    send(4'b0110, 3'd2);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = MapIdent;
    @(negedge CLK);
    bus.cfg_we = 1'b0;
`ifdef ARRAY_SELECT_CFG_ERR_EN
    check_eq("err_pulse", 32'(bus.cfg_err), 32'd1);
`endif
    @(negedge CLK);
`ifdef ARRAY_SELECT_CFG_ERR_EN
    check_eq("err_clear", 32'(bus.cfg_err), 32'd0);
`endif
    wait_out("locked", 0, 4'b1000);
    drain();
    send(4'b0110, 3'd2);
    wait_out("locked_rerun", 2, 4'b1000);
    drain();

    // Bypass
    send(4'b1011, 3'd0);
    wait_out("bypass", 0, 4'b1011);
    drain();

    // Config write in the accept cycle is used by that word
    cfg_write(2'd1, MapRotl);
    cfg_write(2'd2, MapRotl);
    cfg_write(2'd3, MapRotl);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = MapRotl;
    send(4'b0011, 3'd1);
    bus.cfg_we = 1'b0;
    wait_out("cfg_acc", 1, 4'b0110);
    drain();

    // Step count clamps to STEPS (7 -> 4 rotations)
    send(4'b0011, 3'd7);
    wait_out("clamp", 4, 4'b0011);
    drain();

    // Asynchronous reset mid-run
    send(4'b0011, 3'd4);
    check_eq("run_hold_data", 32'(bus.out_data), 32'b0011);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_data", 32'(bus.out_data), 32'd0);
    check_eq("arst_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_rdy", 32'(bus.in_ready), 32'd1);
    check_eq("post_rst_valid", 32'(bus.out_valid), 32'd0);
    send(4'b0110, 3'd4);
    wait_out("post_rst_ident", 4, 4'b0110);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_select_sequencer.md
Name: array_select_sequencer

Overview:
- Multi-pass bit-select engine for WIDTH-bit words.
- Each pass rebuilds every output bit from one of 2*WIDTH sources: the original input word bits, or the previous pass result bits.
- Per-pass select maps live in a small programmable table; one pass is evaluated per clock through a single shared select stage.
- Sits between a valid/ready producer and consumer; replaces hard-wired chains of select/concat wiring between instances.

Parameters:
- WIDTH, 4, data word width.
- STEPS, 4, table depth = max passes per transaction.
- SEL_W, $clog2(2*WIDTH), per-bit selector width (derived, do not override).
- AW, $clog2(STEPS), table address width (derived).

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_steps  in  AW+1  pass count N for this word; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result word.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table entry (pass index).
- cfg_data  in  WIDTH*SEL_W  select map; field [i*SEL_W +: SEL_W] drives result bit i.

Behaviour:
- Reset: asynchronous on ASYNCRESETN low, independent of CLK.
  - State goes to IDLE; in_ready=0 while reset is held; out_valid=0, out_data=0.
  - Orig/work registers clear to 0.
  - Every table entry resets to identity: bit i sel = i.
  - Reset mid-transaction discards the transaction; no out_valid for it.
- Sources:
  - Sel s < WIDTH selects orig[s].
  - Sel WIDTH <= s < 2*WIDTH selects work[s-WIDTH].
  - Sel >= 2*WIDTH (only possible when WIDTH is not a power of 2) yields 0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept on in_valid & in_ready edge: orig<=in_data, work<=in_data, Ncap=min(in_steps,STEPS), step<=0.
  - Next state is DONE if Ncap==0, else RUN.
- State RUN:
  - in_ready=0.
  - Each edge: work <= select(table[step], orig, work); step++.
  - After the Ncap-th pass edge, go to DONE.
  - Latency: out_valid visible after Ncap edges following the accept edge (Ncap=0: after the accept edge itself).
- State DONE:
  - out_valid=1, out_data=work.
  - Holds stable until out_ready is high at an edge, then returns to IDLE.
  - in_ready=0 (no overlap; one transaction in flight).
- out_data:
  - Registered copy of work, valid only when out_valid=1.
  - Holds its last value otherwise.
  - Zero after reset.
- Config writes:
  - Accepted only in IDLE; they take effect at that edge.
  - cfg_we and accept in the same IDLE cycle: the new entry is used by the transaction being accepted.
  - cfg_we in RUN or DONE is dropped; the table is unchanged.
- in_steps is ignored except at accept. Changing it, or the table contents, after accept has no effect on the transaction in flight.

Optional Feature:
- Macro: ARRAY_SELECT_CFG_ERR_EN.
- When defined:
  - Extra port cfg_err, out, 1.
  - cfg_err is a registered 1-cycle pulse the edge after any cfg_we sampled outside IDLE.
  - cfg_err resets to 0.
- When undefined: no port; out-of-IDLE writes are dropped silently.

Test Plan:
- Reset defaults: after reset, in=4'b0110, in_steps=2, out_ready=1 -> out_valid after 2 edges, out_data=4'b0110 (identity table); in_ready low during RUN/DONE.
- Two-pass chain:
  - Setup: table[0] sel (bit3..0)={2,1,0,0}, table[1]={1,5,5,4}.
  - Stimulus: in=4'b0110, N=2.
  - Response: pass0 work=4'b1100; out_data=4'b1000 after 2 edges.
- Backpressure: as above with out_ready=0 for 5 cycles -> out_valid and out_data=4'b1000 held stable, in_ready=0; raise out_ready -> IDLE next edge, in_ready=1.
- Bypass and clamp: N=0, in=4'b1011 -> out_valid one edge after accept, out_data=4'b1011; N=7 with STEPS=4 -> exactly 4 passes.
- Locked config: cfg_we to entry 0 during RUN -> table unchanged (next identical run gives same result); with ARRAY_SELECT_CFG_ERR_EN, cfg_err=1 for exactly one cycle.
- Reset mid-run: drop ASYNCRESETN in RUN -> out_valid=0 and out_data=0 immediately without a clock edge; after release in_ready=1 and table is identity.
